// File: rtl/con_sched.sv
// Round-constant scheduler: drives a 16-bit constant generator, packs HI/LO halves
// into 32-bit words and buffers them in a FIFO. Define CON_SCHED_IDX_EN to add con_idx.
module con_sched #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  key_len,
    output logic [15:0] gen_iv,
    output logic        gen_sel,
    output logic        gen_sel2,
    output logic        gen_en,
    input  logic [15:0] con_in,
    output logic [31:0] con_out,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        busy,
    output logic        done
`ifdef CON_SCHED_IDX_EN
    ,
    output logic [6:0]  con_idx
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] STALL_LVL = (AW + 1)'(FIFO_DEPTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_STALL = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [15:0]   iv_q, iv_d;
    logic [6:0]    tgt_q, tgt_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [15:0]   hi_q, hi_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [31:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   lvl_after_push;
    logic          push;
    logic          pop;

    assign con_valid = (count_q != '0);
    assign pop       = con_valid && con_ready;
    assign con_out   = mem_q[rd_ptr_q];
    assign gen_iv    = iv_q;
    assign gen_sel   = (state_q == S_HI);
    assign gen_sel2  = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_STALL);
    assign gen_en    = (state_q == S_LOAD) || (state_q == S_HI) || (state_q == S_LO);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DRAIN) && (count_q == '0);

    // Occupancy after this cycle's push, accounting for a concurrent pop.
    assign lvl_after_push = pop ? count_q : count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        iv_d    = iv_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && key_len != 2'b11) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    case (key_len)
                        2'b00:   begin iv_d = 16'h428a; tgt_d = 7'd60; end
                        2'b01:   begin iv_d = 16'h7137; tgt_d = 7'd84; end
                        default: begin iv_d = 16'hb5c0; tgt_d = 7'd92; end
                    endcase
                end
            end
            S_LOAD: state_d = S_HI;
            S_HI: begin
                hi_d    = con_in;
                state_d = S_LO;
            end
            S_LO: begin
                push  = 1'b1;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q + 7'd1 == tgt_q)
                    state_d = S_DRAIN;
                else if (lvl_after_push == STALL_LVL)
                    state_d = S_STALL;
                else
                    state_d = S_HI;
            end
            S_STALL: if (count_q < STALL_LVL) state_d = S_HI;
            S_DRAIN: if (count_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {hi_q, con_in};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            iv_q     <= '0;
            tgt_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            iv_q     <= iv_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef CON_SCHED_IDX_EN
    logic [6:0] idx_q [FIFO_DEPTH];
    logic [6:0] idx_d [FIFO_DEPTH];

    assign con_idx = idx_q[rd_ptr_q];

    always_comb begin
        idx_d = idx_q;
        if (push)
            idx_d[wr_ptr_q] = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx_q <= '{default: '0};
        else
            idx_q <= idx_d;
    end
`endif

endmodule

// File: doc/con_sched.md
CON_SCHED -- requirements
Module: con_sched

Interface
REQ-001 SHALL have the parameter FIFO_DEPTH, default 4, giving the number of 32-bit entries in the output buffer; it SHALL be a power of two and at least 2.
REQ-002 SHALL have the port clk, input, width 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have the port rst_n, input, width 1: reset, asynchronous, active-low.
REQ-004 SHALL have the port start, input, width 1: a one-cycle pulse that begins a constant run; it is ignored while busy=1.
REQ-005 SHALL have the port key_len, input, width 2: 00 means 128-bit, 01 means 192-bit, 10 means 256-bit, 11 is illegal; sampled with start.
REQ-006 SHALL have the port gen_iv, output, width 16: the IV for the generator; 428a for 128-bit, 7137 for 192-bit, b5c0 for 256-bit.
REQ-007 SHALL have the port gen_sel, output, width 1: half select to the generator; 1 selects the upper (even) half, 0 selects the lower (odd) half.
REQ-008 SHALL have the port gen_sel2, output, width 1: 0 loads the generator with gen_iv; 1 runs the generator.
REQ-009 SHALL have the port gen_en, output, width 1: generator state advance enable; 0 freezes the generator.
REQ-010 SHALL have the port con_in, input, width 16: the generator's 16-bit constant, valid one cycle after gen_sel/gen_sel2 are driven.
REQ-011 SHALL have the port con_out, output, width 32: the packed constant at the FIFO head.
REQ-012 SHALL have the port con_valid, output, width 1: con_out holds a valid constant.
REQ-013 SHALL have the port con_ready, input, width 1: the consumer accepts con_out.
REQ-014 SHALL have the port busy, output, width 1: a run is in progress.
REQ-015 SHALL have the port done, output, width 1: one-cycle pulse when the last constant of a run is popped.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD, HI, LO, STALL, DRAIN.
REQ-017 SHALL move from IDLE to LOAD on start with a legal key_len; an illegal key_len SHALL leave the block in IDLE with done kept at 0.
REQ-018 SHALL spend exactly one cycle in LOAD, driving gen_sel2=0 and gen_en=1, then go to HI.
REQ-019 SHALL, in HI, drive gen_sel=1 and gen_sel2=1 and latch con_in as bits [31:16] on the following edge; it then goes to LO.
REQ-020 SHALL, in LO, drive gen_sel=0 and latch con_in as bits [15:0]; the assembled word SHALL be pushed into the FIFO on the same edge, then the FSM goes to HI.
REQ-021 SHALL generate per run a word count of 60 for 128-bit, 84 for 192-bit and 92 for 256-bit keys, counted by a 7-bit counter.
REQ-022 SHALL, after the final push, go to DRAIN, stay there until the FIFO is empty, pulse done, then return to IDLE.
REQ-023 SHALL enter STALL instead of HI when the FIFO holds FIFO_DEPTH-1 entries after a push; it SHALL drive gen_en=0 in STALL and resume at HI once the count drops below FIFO_DEPTH-1.
REQ-024 SHALL never push into a full FIFO and never pop from an empty one.
REQ-025 SHALL pop when con_valid=1 and con_ready=1; a simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-026 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-027 SHALL keep con_out stable while con_valid=1 and con_ready=0.
REQ-028 SHALL hold busy=1 in every state except IDLE.

Reset
REQ-029 SHALL, on rst_n low, immediately go to IDLE and clear the FIFO, the pointers and the counters, with busy=0, done=0, con_valid=0, gen_sel=0, gen_sel2=0, gen_en=0, gen_iv=0000 and con_out=00000000.
REQ-030 SHALL discard a run in progress when reset is applied mid-run; no done pulse SHALL be produced for that run.

Configuration
REQ-031 SHALL, with the macro CON_SCHED_IDX_EN defined, add the output con_idx [6:0] giving the run index (0 upward) of the word at the FIFO head, reset to 0.
REQ-032 SHALL, without CON_SCHED_IDX_EN, have no con_idx port and no index storage; all other behaviour SHALL be identical.

Verification
REQ-033 SHALL pass this scenario: key_len=00, start, con_ready held at 1 -> gen_iv=428a in LOAD, exactly 60 pops, done one cycle after the 60th pop.
REQ-034 SHALL pass this scenario: key_len=01 and then 10 -> gen_iv 7137 and b5c0, with 84 and 92 words respectively.
REQ-035 SHALL pass this scenario: con_ready=0 throughout -> after 3 pushes gen_en=0 and the FSM is in STALL; releasing con_ready resumes generation with no word lost or duplicated.
REQ-036 SHALL pass this scenario: a stubbed generator returning 1111 in HI and 2222 in LO -> con_out=11112222.
REQ-037 SHALL pass this scenario: rst_n low at word 17 -> all outputs at reset values immediately, and a following start produces a clean 60-word run.
REQ-038 SHALL pass this scenario: start with key_len=11, or start while busy -> ignored, with no state change.
